// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one ALU among NREQ requesters and
// returns each captured result, tagged with the owner id, on a valid/ready channel.
module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       grant,
  output logic [2:0]            alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_ovf,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_ovf,
  output logic                  busy
);

  localparam int CNTW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic [CNTW-1:0] cnt;
  logic [IDW-1:0]  winner;
  logic            found;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // Response channel: a transfer happens on any rising edge where rsp_valid
  // and rsp_ready are both high; once raised, rsp_valid and its payload
  // (rsp_id, rsp_data, rsp_ovf) stay stable until that transfer.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    grant      = '0;
    state_next = state;
    // Scan downward so the smallest offset from ptr is the last to win.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[rr_index(ptr, i)]) begin
        found  = 1'b1;
        winner = rr_index(ptr, i);
      end
    end
    ptr_next = rr_index(winner, 1);
    case (state)
      IDLE: begin
        if (found && reset_n) begin
          grant[winner] = 1'b1;
          state_next    = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (found) begin
            alu_op <= req_op[3*int'(winner) +: 3];
            alu_a  <= req_a[WIDTH*int'(winner) +: WIDTH];
            alu_b  <= req_b[WIDTH*int'(winner) +: WIDTH];
            rsp_id <= winner;
            ptr    <= ptr_next;
            cnt    <= CNTW'(ALU_LAT - 1);
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
          end else begin
            rsp_data  <= alu_result;
            rsp_ovf   <= alu_ovf;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = reset_n && (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at ALU_LAT=1 and one at
// ALU_LAT=3, each with a small combinational ALU stub.
module tb_alu_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [IDW+WIDTH-1:0] exp_q[$];

  // Instance with ALU_LAT=1
  logic                  reset_n1;
  logic [NREQ-1:0]       req1;
  logic [3*NREQ-1:0]     op1;
  logic [WIDTH*NREQ-1:0] a1, b1;
  logic [NREQ-1:0]       grant1;
  logic [2:0]            alu_op1;
  logic [WIDTH-1:0]      alu_a1, alu_b1, alu_result1, rsp_data1;
  logic                  alu_ovf1, rsp_valid1, rsp_ready1, rsp_ovf1, busy1;
  logic [IDW-1:0]        rsp_id1;
  logic                  stub_dead1;

  // Instance with ALU_LAT=3
  logic                  reset_n3;
  logic [NREQ-1:0]       req3;
  logic [3*NREQ-1:0]     op3;
  logic [WIDTH*NREQ-1:0] a3, b3;
  logic [NREQ-1:0]       grant3;
  logic [2:0]            alu_op3;
  logic [WIDTH-1:0]      alu_a3, alu_b3, alu_result3, rsp_data3;
  logic                  alu_ovf3, rsp_valid3, rsp_ready3, rsp_ovf3, busy3;
  logic [IDW-1:0]        rsp_id3;

  assign alu_result1 = stub_dead1 ? 32'hDEAD_BEEF : alu_a1 + alu_b1;
  assign alu_ovf1    = 1'b0;
  assign alu_result3 = alu_a3 ^ alu_b3;
  assign alu_ovf3    = (alu_op3 == 3'b111);

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .ALU_LAT(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n1), .req(req1), .req_op(op1), .req_a(a1), .req_b(b1),
    .grant(grant1), .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_result(alu_result1), .alu_ovf(alu_ovf1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1), .rsp_id(rsp_id1), .rsp_data(rsp_data1),
    .rsp_ovf(rsp_ovf1), .busy(busy1)
  );

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .ALU_LAT(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n3), .req(req3), .req_op(op3), .req_a(a3), .req_b(b3),
    .grant(grant3), .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_result(alu_result3), .alu_ovf(alu_ovf3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .rsp_ovf(rsp_ovf3), .busy(busy3)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_next();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0]      rr_exp [5];
    logic [IDW+WIDTH-1:0] exp_item;
    int k;
    int last_cyc;

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_n1 = 1'b0; reset_n3 = 1'b0;
    req1 = 4'b1111; req3 = '0;
    op1 = '0; op3 = '0; a3 = '0; b3 = '0;
    rsp_ready1 = 1'b1; rsp_ready3 = 1'b1; stub_dead1 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a1[WIDTH*i +: WIDTH] = 32'(10 * i + 1);
      b1[WIDTH*i +: WIDTH] = 32'(i + 2);
    end

    // Reset held for three cycles with all requests asserted
    for (int i = 0; i < 3; i++) begin
      cyc_next; settle;
      check_eq("rst_grant", grant1, 0);
      check_eq("rst_valid", rsp_valid1, 0);
      check_eq("rst_busy", busy1, 0);
      check_eq("rst_alu_a", alu_a1, 0);
      check_eq("rst_alu_op", alu_op1, 0);
    end

    // Release and round-robin over all four requesters
    cyc_next; reset_n1 = 1'b1;
    k = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc > 0) cyc_next;
      settle;
      if (cyc == 0) check_eq("release_grant", grant1, 4'b0001);
      if (grant1 != '0) begin
        if (k < 5) begin
          check_eq("rr_grant", grant1, rr_exp[k]);
          if (k > 0) check_eq("rr_gap", cyc - last_cyc, 3);
          exp_q.push_back({IDW'(k % NREQ), 32'(11 * (k % NREQ) + 3)});
        end else begin
          check_eq("rr_extra_grant", grant1, 0);
        end
        last_cyc = cyc;
        k++;
      end
      if (rsp_valid1 && rsp_ready1) begin
        check_eq("rr_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          check_eq("rr_rsp", {rsp_id1, rsp_data1}, exp_item);
        end
      end
    end
    req1 = '0;
    check_eq("rr_count", k, 5);
    check_eq("rr_drain", exp_q.size(), 0);

    // Single op from requester 2 (ptr is now 1)
    cyc_next;
    op1[8:6] = 3'b010; a1[95:64] = 32'd5; b1[95:64] = 32'd3; req1 = 4'b0100;
    settle;
    check_eq("single_grant", grant1, 4'b0100);
    check_eq("single_idle_busy", busy1, 0);
    cyc_next; req1 = '0; settle;
    check_eq("single_alu_op", alu_op1, 3'b010);
    check_eq("single_alu_a", alu_a1, 5);
    check_eq("single_alu_b", alu_b1, 3);
    check_eq("single_busy", busy1, 1);
    check_eq("single_c1_valid", rsp_valid1, 0);
    cyc_next; settle;
    check_eq("single_valid", rsp_valid1, 1);
    check_eq("single_id", rsp_id1, 2);
    check_eq("single_data", rsp_data1, 8);
    check_eq("single_resp_grant", grant1, 0);
    cyc_next; settle;
    check_eq("single_done_busy", busy1, 0);
    check_eq("single_done_valid", rsp_valid1, 0);

    // Backpressure: ptr is 3, so 0011 picks requester 0 first
    cyc_next;
    stub_dead1 = 1'b1; rsp_ready1 = 1'b0; req1 = 4'b0011;
    settle;
    check_eq("bp_grant", grant1, 4'b0001);
    cyc_next; settle;
    check_eq("bp_exec_grant", grant1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc_next; settle;
      check_eq("bp_valid", rsp_valid1, 1);
      check_eq("bp_data", rsp_data1, 32'hDEAD_BEEF);
      check_eq("bp_id", rsp_id1, 0);
      check_eq("bp_grant_hold", grant1, 0);
    end
    cyc_next; rsp_ready1 = 1'b1; settle;
    check_eq("bp_hs_valid", rsp_valid1, 1);
    check_eq("bp_hs_grant", grant1, 0);
    cyc_next; settle;
    check_eq("bp_next_grant", grant1, 4'b0010);
    check_eq("bp_next_valid", rsp_valid1, 0);
    cyc_next; req1 = '0;
    cyc_next; settle;
    check_eq("bp2_id", rsp_id1, 1);
    check_eq("bp2_data", rsp_data1, 32'hDEAD_BEEF);
    cyc_next; settle;
    check_eq("bp2_busy", busy1, 0);

    // ALU_LAT=3 with overflow-raising op 7 from requester 1
    cyc_next;
    reset_n3 = 1'b1;
    op3[5:3] = 3'b111; a3[63:32] = 32'h1234_0000; b3[63:32] = 32'h0000_5678;
    req3 = 4'b0010;
    settle;
    check_eq("lat_grant", grant3, 4'b0010);
    cyc_next; req3 = '0; settle;
    check_eq("lat_alu_op", alu_op3, 3'b111);
    check_eq("lat_alu_a", alu_a3, 32'h1234_0000);
    check_eq("lat_alu_b", alu_b3, 32'h0000_5678);
    check_eq("lat_c1_valid", rsp_valid3, 0);
    for (int i = 0; i < 2; i++) begin
      cyc_next; settle;
      check_eq("lat_hold_a", alu_a3, 32'h1234_0000);
      check_eq("lat_hold_b", alu_b3, 32'h0000_5678);
      check_eq("lat_wait_valid", rsp_valid3, 0);
      check_eq("lat_busy", busy3, 1);
    end
    cyc_next; settle;
    check_eq("lat_valid", rsp_valid3, 1);
    check_eq("lat_ovf", rsp_ovf3, 1);
    check_eq("lat_data", rsp_data3, 32'h1234_5678);
    check_eq("lat_id", rsp_id3, 1);
    cyc_next; settle;
    check_eq("lat_done_busy", busy3, 0);

    // Reset during the second EXEC cycle drops the operation
    cyc_next;
    op3[8:6] = 3'b000; a3[95:64] = 32'd7; b3[95:64] = 32'd9; req3 = 4'b0100;
    settle;
    check_eq("mid_grant", grant3, 4'b0100);
    cyc_next; req3 = '0; settle;
    check_eq("mid_busy", busy3, 1);
    cyc_next; reset_n3 = 1'b0; req3 = 4'b1000; settle;
    check_eq("mid_rst_grant", grant3, 0);
    check_eq("mid_rst_busy", busy3, 0);
    cyc_next; settle;
    check_eq("mid_after_busy", busy3, 0);
    check_eq("mid_after_valid", rsp_valid3, 0);
    check_eq("mid_after_alu_a", alu_a3, 0);
    cyc_next;
    reset_n3 = 1'b1; a3[127:96] = 32'h0000_00F0; b3[127:96] = 32'h0000_000F;
    settle;
    check_eq("mid_release_grant", grant3, 4'b1000);
    cyc_next; req3 = '0;
    for (int i = 0; i < 3; i++) begin
      settle;
      check_eq("mid_no_valid", rsp_valid3, 0);
      cyc_next;
    end
    settle;
    check_eq("mid_new_valid", rsp_valid3, 1);
    check_eq("mid_new_id", rsp_id3, 3);
    check_eq("mid_new_data", rsp_data3, 32'h0000_00FF);
    check_eq("mid_new_ovf", rsp_ovf3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
